// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 4-digit segment scan multiplexer.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_e;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;

    // Scan order: hours tens first, minutes units last.
    localparam logic [1:0] SLOT_HXXX = 2'd0;
    localparam logic [1:0] SLOT_XHXX = 2'd1;
    localparam logic [1:0] SLOT_XXMX = 2'd2;
    localparam logic [1:0] SLOT_XXXM = 2'd3;

    localparam logic [3:0] DIG_HXXX = 4'b1000;
    localparam logic [3:0] DIG_XHXX = 4'b0100;
    localparam logic [3:0] DIG_XXMX = 4'b0010;
    localparam logic [3:0] DIG_XXXM = 4'b0001;

    function automatic logic [3:0] slot_to_dig(input logic [1:0] slot);
        logic [3:0] dig;
        case (slot)
            SLOT_HXXX: dig = DIG_HXXX;
            SLOT_XHXX: dig = DIG_XHXX;
            SLOT_XXMX: dig = DIG_XXMX;
            SLOT_XXXM: dig = DIG_XXXM;
            default:   dig = 4'b0000;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot / cycle-in-slot counters and brightness window comparator for seg_scan_mux.
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 64,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       run,
    input  logic [2:0] bright,
    output logic [1:0] slot,
    output logic       blank_end,
    output logic       slot_end,
    output logic       snap,
    output logic       lit
);

    localparam int CYC_W = $clog2(DIGIT_CYCLES);
    localparam int ONL_W = CYC_W + 4;
    localparam logic [CYC_W-1:0] CYC_LAST      = CYC_W'(DIGIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_BLANK     = CYC_W'(BLANK_CYCLES);
    localparam logic [CYC_W-1:0] CYC_BLANK_END = CYC_W'(BLANK_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ONE       = CYC_W'(1);

    logic [CYC_W-1:0] cyc_r;
    logic [1:0]       slot_r;
    logic [ONL_W-1:0] span_s;
    logic [ONL_W-1:0] mult_s;
    logic [ONL_W-1:0] on_len_s;
    logic [ONL_W-1:0] rel_s;

    // Counters advance only while scanning; stopping the scan rewinds them.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cyc_r  <= '0;
            slot_r <= '0;
        end else if (!run) begin
            cyc_r  <= '0;
            slot_r <= '0;
        end else if (cyc_r == CYC_LAST) begin
            cyc_r  <= '0;
            slot_r <= slot_r + 2'd1;
        end else begin
            cyc_r  <= cyc_r + CYC_ONE;
            slot_r <= slot_r;
        end
    end

    // PWM window: full product kept before the divide-by-8 shift.
    always_comb begin
        span_s    = ONL_W'(DIGIT_CYCLES - BLANK_CYCLES);
        mult_s    = span_s * ONL_W'({1'b0, bright} + 4'd1);
        on_len_s  = mult_s >> 2'd3;
        rel_s     = ONL_W'(cyc_r) - ONL_W'(CYC_BLANK);
        lit       = (cyc_r >= CYC_BLANK) && (rel_s < on_len_s);
        blank_end = (cyc_r == CYC_BLANK_END);
        slot_end  = (cyc_r == CYC_LAST);
        snap      = (cyc_r == '0) && (slot_r == SLOT_HXXX);
        slot      = slot_r;
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes four 7-segment digits onto one bus with blanking, PWM and frame snapshots.
// Optional colon blink output enabled by defining SEG_SCAN_COLON_EN.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 64,
    parameter int BLANK_CYCLES = 4,
    parameter int COLON_HALF   = 16384
) (
    input  logic             sysclk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic [2:0]       bright_i,
    input  logic [SEG_W-1:0] seg_hxxx_i,
    input  logic [SEG_W-1:0] seg_xhxx_i,
    input  logic [SEG_W-1:0] seg_xxmx_i,
    input  logic [SEG_W-1:0] seg_xxxm_i,
    output logic [SEG_W-1:0] seg_o,
    output logic [3:0]       dig_o,
    output logic             frame_o,
    output logic             colon_o
);

    scan_state_e      state_r;
    scan_state_e      state_nxt_s;
    logic [SEG_W-1:0] shadow_r [NUM_DIGITS];
    logic [2:0]       bright_sh_r;
    logic             run_s;
    logic [1:0]       slot_s;
    logic             blank_end_s;
    logic             slot_end_s;
    logic             snap_s;
    logic             lit_s;
    logic             lit_on_s;
    logic [SEG_W-1:0] seg_nxt_s;
    logic [3:0]       dig_nxt_s;
    logic             frame_nxt_s;
    logic             colon_nxt_s;

    assign run_s = en_i && (state_r != IDLE);

    seg_scan_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk       (sysclk_i),
        .rstn      (rstn_i),
        .run       (run_s),
        .bright    (bright_sh_r),
        .slot      (slot_s),
        .blank_end (blank_end_s),
        .slot_end  (slot_end_s),
        .snap      (snap_s),
        .lit       (lit_s)
    );

    // Scan state register.
    always_ff @(posedge sysclk_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; dropping en_i aborts the frame from any state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (en_i) state_nxt_s = BLANK;
                else      state_nxt_s = IDLE;
            end
            BLANK: begin
                if (!en_i)            state_nxt_s = IDLE;
                else if (blank_end_s) state_nxt_s = ON;
                else                  state_nxt_s = BLANK;
            end
            ON: begin
                if (!en_i)           state_nxt_s = IDLE;
                else if (slot_end_s) state_nxt_s = BLANK;
                else                 state_nxt_s = ON;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Inputs are sampled only at the start of a frame so a frame never tears.
    always_ff @(posedge sysclk_i) begin
        if (!rstn_i) begin
            shadow_r[SLOT_HXXX] <= '0;
            shadow_r[SLOT_XHXX] <= '0;
            shadow_r[SLOT_XXMX] <= '0;
            shadow_r[SLOT_XXXM] <= '0;
            bright_sh_r         <= 3'd0;
        end else if (run_s && snap_s) begin
            shadow_r[SLOT_HXXX] <= seg_hxxx_i;
            shadow_r[SLOT_XHXX] <= seg_xhxx_i;
            shadow_r[SLOT_XXMX] <= seg_xxmx_i;
            shadow_r[SLOT_XXXM] <= seg_xxxm_i;
            bright_sh_r         <= bright_i;
        end else begin
            bright_sh_r         <= bright_sh_r;
        end
    end

`ifdef SEG_SCAN_COLON_EN
    localparam int BLINK_W = $clog2(COLON_HALF);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(COLON_HALF - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    logic [BLINK_W-1:0] blink_cnt_r;
    logic               phase_r;

    // Colon blink timebase; restarts in the lit phase whenever scanning restarts.
    always_ff @(posedge sysclk_i) begin
        if (!rstn_i) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b1;
        end else if (!run_s) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b1;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            phase_r     <= ~phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_ONE;
            phase_r     <= phase_r;
        end
    end

    // Colon rides on the xhxx digit's select line and PWM window.
    always_comb begin
        colon_nxt_s = phase_r && lit_on_s && (slot_s == SLOT_XHXX);
    end
`else
    // Colon output kept for a stable pinout.
    always_comb begin
        colon_nxt_s = 1'b0;
    end
`endif

    // Output pattern for the current slot position.
    always_comb begin
        lit_on_s    = run_s && (state_r == ON) && lit_s;
        seg_nxt_s   = '0;
        dig_nxt_s   = 4'b0000;
        frame_nxt_s = run_s && snap_s;
        if (lit_on_s) begin
            seg_nxt_s = shadow_r[slot_s];
            dig_nxt_s = slot_to_dig(slot_s);
        end else begin
            seg_nxt_s = '0;
            dig_nxt_s = 4'b0000;
        end
    end

    // Registered pad outputs.
    always_ff @(posedge sysclk_i) begin
        if (!rstn_i) begin
            seg_o   <= '0;
            dig_o   <= 4'b0000;
            frame_o <= 1'b0;
            colon_o <= 1'b0;
        end else begin
            seg_o   <= seg_nxt_s;
            dig_o   <= dig_nxt_s;
            frame_o <= frame_nxt_s;
            colon_o <= colon_nxt_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a frame-position reference model queues expected outputs per edge.
module tb_seg_scan_mux;

    localparam int DC    = 64;
    localparam int BC    = 4;
    localparam int FR    = 4 * DC;
    localparam int HALF  = 16384;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       frame;
        logic       colon;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [2:0] bright;
    logic [6:0] s_h, s_xh, s_xm, s_m;
    logic [6:0] seg_o;
    logic [3:0] dig_o;
    logic       frame_o;
    logic       colon_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    exp_t mon_e;

    // reference model state: position within the scan, counted in enabled edges
    bit         m_active = 1'b0;
    int         m_k      = 0;
    logic [6:0] m_sh[4];
    logic [2:0] m_b      = 3'd0;

    seg_scan_mux dut (
        .sysclk_i   (clk),
        .rstn_i     (rstn),
        .en_i       (en),
        .bright_i   (bright),
        .seg_hxxx_i (s_h),
        .seg_xhxx_i (s_xh),
        .seg_xxmx_i (s_xm),
        .seg_xxxm_i (s_m),
        .seg_o      (seg_o),
        .dig_o      (dig_o),
        .frame_o    (frame_o),
        .colon_o    (colon_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge();
        exp_t e;
        int   p, slot, c, on_len;
        e = '0;
        if (!rstn) begin
            m_active = 1'b0;
            m_k      = 0;
            for (int i = 0; i < 4; i++) m_sh[i] = 7'd0;
            m_b = 3'd0;
        end else if (!en) begin
            m_active = 1'b0;
            m_k      = 0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_k      = 0;
        end else begin
            p    = m_k % FR;
            slot = p / DC;
            c    = p % DC;
            if (p == 0) begin
                m_sh[0] = s_h; m_sh[1] = s_xh; m_sh[2] = s_xm; m_sh[3] = s_m;
                m_b     = bright;
                e.frame = 1'b1;
            end
            on_len = ((DC - BC) * (int'(m_b) + 1)) / 8;
            if (c >= BC && (c - BC) < on_len) begin
                e.dig = 4'b1000 >> slot;
                e.seg = m_sh[slot];
`ifdef SEG_SCAN_COLON_EN
                if (slot == 1 && ((m_k / HALF) % 2) == 0) e.colon = 1'b1;
`endif
            end
            m_k++;
        end
        q.push_back(e);
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
    endtask

    task automatic wait_pos(input int target);
        int i;
        i = 0;
        while (!(m_active && (m_k % FR) == target) && i < 2 * FR) begin
            tick();
            i++;
        end
        n_checks++;
        if (!(m_active && (m_k % FR) == target)) begin
            n_fail++;
            $display("FAIL wait_pos: position %0d not reached, got %0d", target, m_k % FR);
        end
    endtask

    // monitor: one output tuple is presented every clock
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_checks++;
            if ({seg_o, dig_o, frame_o, colon_o} !== mon_e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got seg=%h dig=%b frame=%b colon=%b, expected seg=%h dig=%b frame=%b colon=%b",
                         $time, seg_o, dig_o, frame_o, colon_o, mon_e.seg, mon_e.dig, mon_e.frame, mon_e.colon);
            end
        end
    end

    initial begin
        rstn = 1'b0; en = 1'b0; bright = 3'd0;
        s_h = 7'd0; s_xh = 7'd0; s_xm = 7'd0; s_m = 7'd0;
        @(negedge clk);
        repeat (3) tick();
        rstn = 1'b1;
        repeat (2) tick();

        // full brightness, clock digits
        bright = 3'd7; s_h = 7'h06; s_xh = 7'h5B; s_xm = 7'h4F; s_m = 7'h66; en = 1'b1;
        repeat (600) tick();
        bright = 3'd0;
        repeat (300) tick();
        bright = 3'd3;
        repeat (300) tick();

        // pattern change inside slot 1 must wait for the next frame
        wait_pos(DC + 10);
        s_xm = 7'h7F;
        repeat (600) tick();

        // abort at slot 2 cycle 20, then restart
        wait_pos(2 * DC + 20);
        en = 1'b0;
        repeat (2) tick();
        en = 1'b1;
        repeat (300) tick();

        // one-cycle reset while a digit is lit
        wait_pos(DC + 30);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (300) tick();

        // randomized inputs, brightness, enable and reset activity
        repeat (4000) begin
            if ($urandom_range(0, 99) == 0) begin
                s_h = 7'($urandom); s_xh = 7'($urandom); s_xm = 7'($urandom); s_m = 7'($urandom);
            end
            if ($urandom_range(0, 199) == 0) bright = 3'($urandom);
            if ($urandom_range(0, 399) == 0) en = ~en;
            else if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
            rstn = ($urandom_range(0, 599) != 0);
            tick();
        end
        rstn = 1'b1; en = 1'b1;

`ifdef SEG_SCAN_COLON_EN
        // span two colon half-periods without interruption
        repeat (2 * HALF + 300) tick();
`endif
        repeat (3) tick();
        @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
